// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and cache line geometry helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Byte offset bit 0 selects a byte inside a word; word index starts above it.
  localparam int unsigned WORD_OFS_LSB = 1;

  // Width in bits of a cache line holding the given number of 16-bit words.
  function automatic int unsigned line_bits(input int unsigned words);
    return 16 * words;
  endfunction

endpackage

// File: rtl/cache_repl_state.sv
// Per-set replacement state with a single touch port and a combinational
// victim read port.
// Build option: CACHE_PLRU_EN selects tree pseudo-LRU; otherwise a per-set
// round-robin counter that only advances on fills.
module cache_repl_state #(
  parameter int WAYS = 2,
  parameter int SETS = 8
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    touch_valid,
  input  logic                    touch_fill,
  input  logic [$clog2(SETS)-1:0] touch_set,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic [$clog2(SETS)-1:0] victim_set,
  output logic [$clog2(WAYS)-1:0] victim_way
);

  localparam int WW = $clog2(WAYS);

`ifdef CACHE_PLRU_EN
  // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1.
  // A node bit of 1 means the victim lies in the upper half of its subtree.
  logic [WAYS-1:1] r_tree [SETS];
  logic [WAYS-1:1] w_tree_next;
  logic [WW-1:0]   w_node;
  logic [WW-1:0]   w_vnode;
  logic            w_unused_fill;

  assign w_unused_fill = touch_fill;

  // Walk the touched way's path and point every node away from it.
  always_comb begin
    w_tree_next = r_tree[touch_set];
    w_node      = WW'(1);
    for (int l = 0; l < WW; l++) begin
      w_tree_next[w_node] = ~touch_way[WW-1-l];
      w_node = (w_node << 1) | WW'(touch_way[WW-1-l]);
    end
  end

  // Tree storage; cleared on reset, updated on any touch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
    end else if (touch_valid) begin
      r_tree[touch_set] <= w_tree_next;
    end
  end

  // Follow node bits from the root to name the victim.
  always_comb begin
    victim_way = '0;
    w_vnode    = WW'(1);
    for (int l = 0; l < WW; l++) begin
      victim_way[WW-1-l] = r_tree[victim_set][w_vnode];
      w_vnode = (w_vnode << 1) | WW'(r_tree[victim_set][w_vnode]);
    end
  end
`else
  logic [WW-1:0] r_cnt [SETS];
  logic          w_unused_way;

  // Request hits do not influence round-robin order, only fills do.
  assign w_unused_way = ^touch_way;

  // Round-robin counters; advance modulo WAYS on each fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_cnt[s] <= '0;
    end else if (touch_valid && touch_fill) begin
      r_cnt[touch_set] <= r_cnt[touch_set] + WW'(1);
    end
  end

  assign victim_way = r_cnt[victim_set];
`endif

endmodule

// File: rtl/cache_line_access.sv
// N-way cache data array: word reads, byte-masked writes with a registered
// response, full-line fills and replacement tracking.
// Build option: CACHE_PLRU_EN (handled inside cache_repl_state).
module cache_line_access
  import lc3b_types::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8
)(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [$clog2(SETS)-1:0]            req_set,
  input  logic [$clog2(WAYS)-1:0]            req_way,
  input  logic [$clog2(LINE_WORDS):0]        req_offset,
  input  logic [15:0]                        req_wdata,
  input  logic [1:0]                         req_wmask,
  output logic                               rsp_valid,
  output logic [15:0]                        rsp_rdata,
  input  logic                               fill_valid,
  input  logic [$clog2(SETS)-1:0]            fill_set,
  input  logic [$clog2(WAYS)-1:0]            fill_way,
  input  logic [line_bits(LINE_WORDS)-1:0]   fill_line,
  input  logic [$clog2(SETS)-1:0]            victim_set,
  output logic [$clog2(WAYS)-1:0]            victim_way
);

  localparam int WI = $clog2(LINE_WORDS);

  lc3b_word                r_data [WAYS][SETS][LINE_WORDS];
  logic                    r_rsp_valid;
  lc3b_word                r_rsp_rdata;

  logic                    w_req_acc;
  logic [WI-1:0]           w_widx;
  lc3b_word                w_old_word;
  lc3b_word                w_merged;
  logic                    w_touch_valid;
  logic [$clog2(SETS)-1:0] w_touch_set;
  logic [$clog2(WAYS)-1:0] w_touch_way;

  // Fills own the array for the cycle; requests wait upstream.
  assign req_ready = ~fill_valid;
  assign w_req_acc = req_valid & ~fill_valid;

  assign w_widx     = req_offset[WI:WORD_OFS_LSB];
  assign w_old_word = r_data[req_way][req_set][w_widx];

  // Byte merge of write data over the addressed word.
  always_comb begin
    w_merged = w_old_word;
    if (req_wmask[0]) w_merged[7:0]  = req_wdata[7:0];
    if (req_wmask[1]) w_merged[15:8] = req_wdata[15:8];
  end

  // Line storage, intentionally not reset so data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (fill_valid) begin
      for (int w = 0; w < LINE_WORDS; w++)
        r_data[fill_way][fill_set][w] <= fill_line[16*w +: 16];
    end else if (w_req_acc && req_write) begin
      r_data[req_way][req_set][w_widx] <= w_merged;
    end
  end

  // Response register: one-cycle valid pulse per accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_req_acc;
      if (w_req_acc) r_rsp_rdata <= req_write ? w_merged : w_old_word;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  // Fills and accepted requests never coincide, so one touch port suffices.
  assign w_touch_valid = fill_valid | w_req_acc;
  assign w_touch_set   = fill_valid ? fill_set : req_set;
  assign w_touch_way   = fill_valid ? fill_way : req_way;

  cache_repl_state #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_repl (
    .clk         (clk),
    .reset       (reset),
    .touch_valid (w_touch_valid),
    .touch_fill  (fill_valid),
    .touch_set   (w_touch_set),
    .touch_way   (w_touch_way),
    .victim_set  (victim_set),
    .victim_way  (victim_way)
  );

endmodule
